// File: rtl/pcs_pkg.sv
// Shared definitions for the 1000BASE-X PCS receive path: FSM state codes,
// the recognised special code-groups in both running-disparity columns,
// and the GMII substitution bytes.
package pcs_pkg;

    // Receive FSM state encoding
    localparam logic [3:0] ST_LINK_FAILED     = 4'd0;
    localparam logic [3:0] ST_WAIT_FOR_K      = 4'd1;
    localparam logic [3:0] ST_RX_K            = 4'd2;
    localparam logic [3:0] ST_IDLE_D          = 4'd3;
    localparam logic [3:0] ST_FALSE_CARR      = 4'd4;
    localparam logic [3:0] ST_START_OF_PACKET = 4'd5;
    localparam logic [3:0] ST_RECEIVE         = 4'd6;
    localparam logic [3:0] ST_TRI_RRI         = 4'd7;

    // Special code-groups, bit 9 = a ... bit 0 = j; _N = RD- column, _P = RD+ column
    localparam logic [9:0] K28_5_N = 10'h0FA;  // COMMA
    localparam logic [9:0] K28_5_P = 10'h305;
    localparam logic [9:0] K27_7_N = 10'h368;  // /S/
    localparam logic [9:0] K27_7_P = 10'h097;
    localparam logic [9:0] K29_7_N = 10'h2E8;  // /T/
    localparam logic [9:0] K29_7_P = 10'h117;
    localparam logic [9:0] K23_7_N = 10'h3A8;  // /R/
    localparam logic [9:0] K23_7_P = 10'h057;
    localparam logic [9:0] K30_7_N = 10'h1E8;  // /V/
    localparam logic [9:0] K30_7_P = 10'h217;

    // Octet values reported by the decoder for the recognised K groups
    localparam logic [7:0] K28_5_BYTE = 8'hBC;
    localparam logic [7:0] K27_7_BYTE = 8'hFB;
    localparam logic [7:0] K29_7_BYTE = 8'hFD;
    localparam logic [7:0] K23_7_BYTE = 8'hF7;
    localparam logic [7:0] K30_7_BYTE = 8'hFE;

    // GMII substitution bytes
    localparam logic [7:0] PREAMBLE_DEF      = 8'h55;
    localparam logic [7:0] FALSE_CARRIER_DEF = 8'h0E;

    // True when a code-group equals either disparity column of a special group
    function automatic logic match_pair(input logic [9:0] code,
                                        input logic [9:0] col_n,
                                        input logic [9:0] col_p);
        match_pair = (code == col_n) || (code == col_p);
    endfunction

endpackage

// File: rtl/decoder_8b10b.sv
// Combinational 8b/10b decoder. Either running-disparity column is accepted
// and disparity errors are deliberately not reported. Only the five K groups
// the receive path uses are recognised; any other K group reads as invalid.
// K recognition wins over the loose data lookup so that e.g. /S/ (which
// would otherwise alias D27.7 via the alternate 7 coding) decodes as K.
module decoder_8b10b
    import pcs_pkg::*;
(
    input  logic [9:0] code_i,
    output logic       is_k_o,
    output logic       is_d_o,
    output logic [7:0] data_o,
    output logic       invalid_o
);

    // 5b/6b lookup: returns {valid, EDCBA}
    function automatic logic [5:0] dec6(input logic [5:0] g);
        case (g)
            6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
            6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
            6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
            6'b110001:            dec6 = {1'b1, 5'd3};
            6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
            6'b101001:            dec6 = {1'b1, 5'd5};
            6'b011001:            dec6 = {1'b1, 5'd6};
            6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
            6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
            6'b100101:            dec6 = {1'b1, 5'd9};
            6'b010101:            dec6 = {1'b1, 5'd10};
            6'b110100:            dec6 = {1'b1, 5'd11};
            6'b001101:            dec6 = {1'b1, 5'd12};
            6'b101100:            dec6 = {1'b1, 5'd13};
            6'b011100:            dec6 = {1'b1, 5'd14};
            6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
            6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
            6'b100011:            dec6 = {1'b1, 5'd17};
            6'b010011:            dec6 = {1'b1, 5'd18};
            6'b110010:            dec6 = {1'b1, 5'd19};
            6'b001011:            dec6 = {1'b1, 5'd20};
            6'b101010:            dec6 = {1'b1, 5'd21};
            6'b011010:            dec6 = {1'b1, 5'd22};
            6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
            6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
            6'b100110:            dec6 = {1'b1, 5'd25};
            6'b010110:            dec6 = {1'b1, 5'd26};
            6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
            6'b001110:            dec6 = {1'b1, 5'd28};
            6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
            6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
            6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
            default:              dec6 = {1'b0, 5'd0};
        endcase
    endfunction

    // 3b/4b lookup: returns {valid, HGF}; both primary and alternate 7 accepted
    function automatic logic [3:0] dec4(input logic [3:0] g);
        case (g)
            4'b1011, 4'b0100:                   dec4 = {1'b1, 3'd0};
            4'b1001:                            dec4 = {1'b1, 3'd1};
            4'b0101:                            dec4 = {1'b1, 3'd2};
            4'b1100, 4'b0011:                   dec4 = {1'b1, 3'd3};
            4'b1101, 4'b0010:                   dec4 = {1'b1, 3'd4};
            4'b1010:                            dec4 = {1'b1, 3'd5};
            4'b0110:                            dec4 = {1'b1, 3'd6};
            4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
            default:                            dec4 = {1'b0, 3'd0};
        endcase
    endfunction

    logic [5:0] six_s;
    logic [3:0] four_s;
    logic [7:0] k_byte_s;

    // Classify the code-group and produce the decoded octet
    always_comb begin
        six_s    = dec6(code_i[9:4]);
        four_s   = dec4(code_i[3:0]);
        is_k_o   = 1'b0;
        k_byte_s = 8'h00;
        if (match_pair(code_i, K28_5_N, K28_5_P)) begin
            is_k_o   = 1'b1;
            k_byte_s = K28_5_BYTE;
        end else if (match_pair(code_i, K27_7_N, K27_7_P)) begin
            is_k_o   = 1'b1;
            k_byte_s = K27_7_BYTE;
        end else if (match_pair(code_i, K29_7_N, K29_7_P)) begin
            is_k_o   = 1'b1;
            k_byte_s = K29_7_BYTE;
        end else if (match_pair(code_i, K23_7_N, K23_7_P)) begin
            is_k_o   = 1'b1;
            k_byte_s = K23_7_BYTE;
        end else if (match_pair(code_i, K30_7_N, K30_7_P)) begin
            is_k_o   = 1'b1;
            k_byte_s = K30_7_BYTE;
        end else begin
            is_k_o   = 1'b0;
            k_byte_s = 8'h00;
        end
        is_d_o    = !is_k_o && six_s[5] && four_s[3];
        invalid_o = !is_k_o && !is_d_o;
        if (is_k_o) begin
            data_o = k_byte_s;
        end else if (is_d_o) begin
            data_o = {four_s[2:0], six_s[4:0]};
        end else begin
            data_o = 8'h00;
        end
    end

endmodule

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive: turns the synchronised code-group stream into
// GMII RXD/RX_DV/RX_ER. Outputs are registered as the entry actions of the
// state being entered, so each sampled code-group appears one Clk later.
module pcs_receive
    import pcs_pkg::*;
#(
    parameter logic [7:0] PREAMBLE      = PREAMBLE_DEF,
    parameter logic [7:0] FALSE_CARRIER = FALSE_CARRIER_DEF
) (
    input  logic        Clk,
    input  logic        mr_main_reset,
    input  logic        code_sync_status,
    input  logic [10:0] SUDI,
    output logic [7:0]  RXD,
    output logic        RX_DV,
    output logic        RX_ER,
    output logic        receiving
);

    logic       rx_even_s;
    logic       dec_is_k_s;
    logic       dec_is_d_s;
    logic [7:0] dec_data_s;
    logic       dec_invalid_s;
    logic       is_comma_s;
    logic       is_s_s;
    logic       is_t_s;
    logic       is_r_s;

    logic [3:0] state_q, state_d;
    logic [7:0] rxd_q, rxd_d;
    logic       rx_dv_q, rx_dv_d;
    logic       rx_er_q, rx_er_d;
    logic       receiving_q, receiving_d;

    assign rx_even_s = SUDI[10];

    decoder_8b10b u_dec (
        .code_i    (SUDI[9:0]),
        .is_k_o    (dec_is_k_s),
        .is_d_o    (dec_is_d_s),
        .data_o    (dec_data_s),
        .invalid_o (dec_invalid_s)
    );

    // Identify the special groups from the decoder's K octet
    always_comb begin
        is_comma_s = dec_is_k_s && (dec_data_s == K28_5_BYTE);
        is_s_s     = dec_is_k_s && (dec_data_s == K27_7_BYTE);
        is_t_s     = dec_is_k_s && (dec_data_s == K29_7_BYTE);
        is_r_s     = dec_is_k_s && (dec_data_s == K23_7_BYTE);
    end

    // Next state and next GMII outputs; loss of sync overrides any code-group
    always_comb begin
        state_d     = state_q;
        rxd_d       = 8'h00;
        rx_dv_d     = 1'b0;
        rx_er_d     = 1'b0;
        receiving_d = 1'b0;
        if (!code_sync_status) begin
            // Flag an error only when a packet was cut short
            state_d = ST_LINK_FAILED;
            rx_er_d = receiving_q;
        end else begin
            case (state_q)
                ST_LINK_FAILED: begin
                    state_d = ST_WAIT_FOR_K;
                end
                ST_WAIT_FOR_K: begin
                    // Stray /R/ (carrier extension) simply keeps us here
                    if (is_comma_s && rx_even_s) begin
                        state_d = ST_RX_K;
                    end else begin
                        state_d = ST_WAIT_FOR_K;
                    end
                end
                ST_RX_K: begin
                    if (dec_is_d_s && !dec_invalid_s) begin
                        state_d = ST_IDLE_D;
                    end else begin
                        state_d = ST_WAIT_FOR_K;
                    end
                end
                ST_IDLE_D: begin
                    if (is_comma_s) begin
                        state_d = ST_RX_K;
                    end else if (is_s_s) begin
                        state_d     = ST_START_OF_PACKET;
                        rxd_d       = PREAMBLE;
                        rx_dv_d     = 1'b1;
                        receiving_d = 1'b1;
                    end else begin
                        state_d = ST_FALSE_CARR;
                        rxd_d   = FALSE_CARRIER;
                        rx_er_d = 1'b1;
                    end
                end
                ST_FALSE_CARR: begin
                    state_d = ST_WAIT_FOR_K;
                end
                ST_START_OF_PACKET, ST_RECEIVE: begin
                    receiving_d = 1'b1;
                    if (dec_is_d_s) begin
                        state_d = ST_RECEIVE;
                        rxd_d   = dec_data_s;
                        rx_dv_d = 1'b1;
                    end else if (is_t_s) begin
                        state_d = ST_TRI_RRI;
                    end else if (is_comma_s && rx_even_s) begin
                        // Packet ended without /T/R/
                        state_d     = ST_RX_K;
                        rx_er_d     = 1'b1;
                        receiving_d = 1'b0;
                    end else begin
                        // /V/, invalid or misplaced K: hold last octet, flag it
                        state_d = ST_RECEIVE;
                        rxd_d   = rxd_q;
                        rx_dv_d = 1'b1;
                        rx_er_d = 1'b1;
                    end
                end
                ST_TRI_RRI: begin
                    state_d = ST_WAIT_FOR_K;
                    if (is_r_s) begin
                        rx_er_d = 1'b0;
                    end else begin
                        rx_er_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_LINK_FAILED;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!mr_main_reset) begin
            state_q     <= ST_LINK_FAILED;
            rxd_q       <= 8'h00;
            rx_dv_q     <= 1'b0;
            rx_er_q     <= 1'b0;
            receiving_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rxd_q       <= rxd_d;
            rx_dv_q     <= rx_dv_d;
            rx_er_q     <= rx_er_d;
            receiving_q <= receiving_d;
        end
    end

    assign RXD       = rxd_q;
    assign RX_DV     = rx_dv_q;
    assign RX_ER     = rx_er_q;
    assign receiving = receiving_q;

endmodule

// File: tb/tb_pcs_receive.sv
// Directed bench for pcs_receive: a table of per-cycle {inputs, expected
// outputs} records plus hand-written sequences for sync loss after /T/ and
// carrier extension.
module tb_pcs_receive;

    logic        Clk;
    logic        mr_main_reset;
    logic        code_sync_status;
    logic [10:0] SUDI;
    logic [7:0]  RXD;
    logic        RX_DV;
    logic        RX_ER;
    logic        receiving;

    int checks;
    int errors;

    pcs_receive dut (
        .Clk              (Clk),
        .mr_main_reset    (mr_main_reset),
        .code_sync_status (code_sync_status),
        .SUDI             (SUDI),
        .RXD              (RXD),
        .RX_DV            (RX_DV),
        .RX_ER            (RX_ER),
        .receiving        (receiving)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // {rx_even, code-group} constants
    localparam logic [10:0] C_E  = {1'b1, 10'h0FA};  // K28.5- even
    localparam logic [10:0] I_O  = {1'b0, 10'h245};  // D16.2+ odd
    localparam logic [10:0] S_E  = {1'b1, 10'h368};  // /S/
    localparam logic [10:0] T_O  = {1'b0, 10'h2E8};  // /T/
    localparam logic [10:0] R_E  = {1'b1, 10'h3A8};  // /R/
    localparam logic [10:0] R_O  = {1'b0, 10'h3A8};
    localparam logic [10:0] T_E  = {1'b1, 10'h2E8};
    localparam logic [10:0] D12O = {1'b0, 10'h13B};  // D18.0 -> 12
    localparam logic [10:0] D12E = {1'b1, 10'h13B};
    localparam logic [10:0] D34E = {1'b1, 10'h0B9};  // D20.1 -> 34
    localparam logic [10:0] D34O = {1'b0, 10'h0B9};
    localparam logic [10:0] D00E = {1'b1, 10'h274};  // D0.0 -> 00
    localparam logic [10:0] DFFO = {1'b0, 10'h2B1};  // D31.7 -> FF
    localparam logic [10:0] BADE = {1'b1, 10'h000};  // invalid
    localparam logic [10:0] DA5O = {1'b0, 10'h29A};  // D5.5 -> A5
    localparam logic [10:0] V_E  = {1'b1, 10'h1E8};  // /V/
    localparam logic [10:0] K281 = {1'b0, 10'h0F9};  // K28.1, unsupported

    typedef struct {
        logic        rst_n;
        logic        sync;
        logic [10:0] sudi;
        logic [7:0]  rxd;
        logic        dv;
        logic        er;
        logic        recv;
        string       name;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst_n, input logic sync, input logic [10:0] sudi,
                                input logic [7:0] rxd, input logic dv, input logic er,
                                input logic recv, input string name);
        vec_t v;
        v.rst_n = rst_n; v.sync = sync; v.sudi = sudi;
        v.rxd = rxd; v.dv = dv; v.er = er; v.recv = recv; v.name = name;
        return v;
    endfunction

    // Drive one code-group, clock it, and compare the registered outputs
    task automatic step(input logic rst_n, input logic sync, input logic [10:0] sudi,
                        input logic [7:0] rxd, input logic dv, input logic er,
                        input logic recv, input string name);
        @(negedge Clk);
        mr_main_reset    = rst_n;
        code_sync_status = sync;
        SUDI             = sudi;
        @(posedge Clk);
        #1;
        checks++;
        if ({RXD, RX_DV, RX_ER, receiving} !== {rxd, dv, er, recv}) begin
            errors++;
            $display("FAIL %s: got RXD=%02h DV=%0b ER=%0b recv=%0b, expected RXD=%02h DV=%0b ER=%0b recv=%0b",
                     name, RXD, RX_DV, RX_ER, receiving, rxd, dv, er, recv);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        mr_main_reset    = 1'b0;
        code_sync_status = 1'b0;
        SUDI             = 11'h000;

        // Reset and idle
        vq.push_back(mk(1'b0, 1'b0, C_E,  8'h00, 1'b0, 1'b0, 1'b0, "reset0"));
        vq.push_back(mk(1'b0, 1'b1, S_E,  8'h00, 1'b0, 1'b0, 1'b0, "reset1"));
        vq.push_back(mk(1'b1, 1'b1, C_E,  8'h00, 1'b0, 1'b0, 1'b0, "lf_to_wait"));
        vq.push_back(mk(1'b1, 1'b1, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "wait_stay"));
        for (int i = 0; i < 4; i++) begin
            vq.push_back(mk(1'b1, 1'b1, C_E, 8'h00, 1'b0, 1'b0, 1'b0, "idle_k"));
            vq.push_back(mk(1'b1, 1'b1, I_O, 8'h00, 1'b0, 1'b0, 1'b0, "idle_d"));
        end
        // Good packet /S/ 12 34 /T/ /R/ /R/ then idle
        vq.push_back(mk(1'b1, 1'b1, S_E,  8'h55, 1'b1, 1'b0, 1'b1, "p1_sop"));
        vq.push_back(mk(1'b1, 1'b1, D12O, 8'h12, 1'b1, 1'b0, 1'b1, "p1_d12"));
        vq.push_back(mk(1'b1, 1'b1, D34E, 8'h34, 1'b1, 1'b0, 1'b1, "p1_d34"));
        vq.push_back(mk(1'b1, 1'b1, T_O,  8'h00, 1'b0, 1'b0, 1'b1, "p1_t"));
        vq.push_back(mk(1'b1, 1'b1, R_E,  8'h00, 1'b0, 1'b0, 1'b0, "p1_r"));
        vq.push_back(mk(1'b1, 1'b1, R_O,  8'h00, 1'b0, 1'b0, 1'b0, "p1_r2"));
        vq.push_back(mk(1'b1, 1'b1, C_E,  8'h00, 1'b0, 1'b0, 1'b0, "p1_k"));
        vq.push_back(mk(1'b1, 1'b1, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "p1_i"));
        // False carrier then resync
        vq.push_back(mk(1'b1, 1'b1, D00E, 8'h0E, 1'b0, 1'b1, 1'b0, "fc"));
        vq.push_back(mk(1'b1, 1'b1, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "fc_after"));
        vq.push_back(mk(1'b1, 1'b1, C_E,  8'h00, 1'b0, 1'b0, 1'b0, "fc_k"));
        vq.push_back(mk(1'b1, 1'b1, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "fc_i"));
        // Packet with invalid, /V/ and unsupported K, bad end-of-packet
        vq.push_back(mk(1'b1, 1'b1, S_E,  8'h55, 1'b1, 1'b0, 1'b1, "p2_sop"));
        vq.push_back(mk(1'b1, 1'b1, DFFO, 8'hFF, 1'b1, 1'b0, 1'b1, "p2_dff"));
        vq.push_back(mk(1'b1, 1'b1, BADE, 8'hFF, 1'b1, 1'b1, 1'b1, "p2_inval"));
        vq.push_back(mk(1'b1, 1'b1, DA5O, 8'hA5, 1'b1, 1'b0, 1'b1, "p2_da5"));
        vq.push_back(mk(1'b1, 1'b1, V_E,  8'hA5, 1'b1, 1'b1, 1'b1, "p2_v"));
        vq.push_back(mk(1'b1, 1'b1, K281, 8'hA5, 1'b1, 1'b1, 1'b1, "p2_k281"));
        vq.push_back(mk(1'b1, 1'b1, D12E, 8'h12, 1'b1, 1'b0, 1'b1, "p2_d12"));
        vq.push_back(mk(1'b1, 1'b1, T_O,  8'h00, 1'b0, 1'b0, 1'b1, "p2_t"));
        vq.push_back(mk(1'b1, 1'b1, D12E, 8'h00, 1'b0, 1'b1, 1'b0, "p2_no_r"));
        vq.push_back(mk(1'b1, 1'b1, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "p2_wait"));
        vq.push_back(mk(1'b1, 1'b1, C_E,  8'h00, 1'b0, 1'b0, 1'b0, "p2_k"));
        vq.push_back(mk(1'b1, 1'b1, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "p2_i"));
        // Early end on comma
        vq.push_back(mk(1'b1, 1'b1, S_E,  8'h55, 1'b1, 1'b0, 1'b1, "p3_sop"));
        vq.push_back(mk(1'b1, 1'b1, D34O, 8'h34, 1'b1, 1'b0, 1'b1, "p3_d34"));
        vq.push_back(mk(1'b1, 1'b1, C_E,  8'h00, 1'b0, 1'b1, 1'b0, "p3_early"));
        vq.push_back(mk(1'b1, 1'b1, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "p3_i"));
        // RX_K followed by a K group drops back to WAIT_FOR_K
        vq.push_back(mk(1'b1, 1'b1, C_E,  8'h00, 1'b0, 1'b0, 1'b0, "rxk_k"));
        vq.push_back(mk(1'b1, 1'b1, T_O,  8'h00, 1'b0, 1'b0, 1'b0, "rxk_t"));
        vq.push_back(mk(1'b1, 1'b1, S_E,  8'h00, 1'b0, 1'b0, 1'b0, "rxk_wait_s"));
        vq.push_back(mk(1'b1, 1'b1, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "rxk_wait_i"));
        vq.push_back(mk(1'b1, 1'b1, C_E,  8'h00, 1'b0, 1'b0, 1'b0, "rxk_k2"));
        vq.push_back(mk(1'b1, 1'b1, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "rxk_i2"));
        // Loss of sync mid-packet
        vq.push_back(mk(1'b1, 1'b1, S_E,  8'h55, 1'b1, 1'b0, 1'b1, "p4_sop"));
        vq.push_back(mk(1'b1, 1'b1, D12O, 8'h12, 1'b1, 1'b0, 1'b1, "p4_d12"));
        vq.push_back(mk(1'b1, 1'b0, D34E, 8'h00, 1'b0, 1'b1, 1'b0, "p4_nosync"));
        vq.push_back(mk(1'b1, 1'b0, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "p4_nosync2"));
        vq.push_back(mk(1'b1, 1'b1, C_E,  8'h00, 1'b0, 1'b0, 1'b0, "p4_lf_exit"));
        vq.push_back(mk(1'b1, 1'b1, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "p4_wait"));
        vq.push_back(mk(1'b1, 1'b1, C_E,  8'h00, 1'b0, 1'b0, 1'b0, "p4_k"));
        vq.push_back(mk(1'b1, 1'b1, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "p4_i"));
        // Reset mid-packet, then loss of sync beats /S/ in IDLE_D
        vq.push_back(mk(1'b1, 1'b1, S_E,  8'h55, 1'b1, 1'b0, 1'b1, "p5_sop"));
        vq.push_back(mk(1'b0, 1'b1, D12O, 8'h00, 1'b0, 1'b0, 1'b0, "p5_reset"));
        vq.push_back(mk(1'b1, 1'b1, C_E,  8'h00, 1'b0, 1'b0, 1'b0, "p5_lf_exit"));
        vq.push_back(mk(1'b1, 1'b1, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "p5_wait"));
        vq.push_back(mk(1'b1, 1'b1, C_E,  8'h00, 1'b0, 1'b0, 1'b0, "p5_k"));
        vq.push_back(mk(1'b1, 1'b1, I_O,  8'h00, 1'b0, 1'b0, 1'b0, "p5_i"));
        vq.push_back(mk(1'b1, 1'b0, S_E,  8'h00, 1'b0, 1'b0, 1'b0, "sync_beats_s"));

        foreach (vq[i]) begin
            step(vq[i].rst_n, vq[i].sync, vq[i].sudi,
                 vq[i].rxd, vq[i].dv, vq[i].er, vq[i].recv, vq[i].name);
        end

        // Sync lost while waiting for /R/ after /T/
        step(1'b1, 1'b1, C_E, 8'h00, 1'b0, 1'b0, 1'b0, "h1_lf_exit");
        step(1'b1, 1'b1, I_O, 8'h00, 1'b0, 1'b0, 1'b0, "h1_wait");
        step(1'b1, 1'b1, C_E, 8'h00, 1'b0, 1'b0, 1'b0, "h1_k");
        step(1'b1, 1'b1, I_O, 8'h00, 1'b0, 1'b0, 1'b0, "h1_i");
        step(1'b1, 1'b1, S_E, 8'h55, 1'b1, 1'b0, 1'b1, "h1_sop");
        step(1'b1, 1'b1, T_O, 8'h00, 1'b0, 1'b0, 1'b1, "h1_t");
        step(1'b1, 1'b0, R_E, 8'h00, 1'b0, 1'b1, 1'b0, "h1_nosync_r");
        step(1'b1, 1'b0, R_O, 8'h00, 1'b0, 1'b0, 1'b0, "h1_nosync2");

        // Long carrier extension after /T/R/ is absorbed silently
        step(1'b1, 1'b1, C_E, 8'h00, 1'b0, 1'b0, 1'b0, "h2_lf_exit");
        step(1'b1, 1'b1, I_O, 8'h00, 1'b0, 1'b0, 1'b0, "h2_wait");
        step(1'b1, 1'b1, C_E, 8'h00, 1'b0, 1'b0, 1'b0, "h2_k");
        step(1'b1, 1'b1, I_O, 8'h00, 1'b0, 1'b0, 1'b0, "h2_i");
        step(1'b1, 1'b1, S_E, 8'h55, 1'b1, 1'b0, 1'b1, "h2_sop");
        step(1'b1, 1'b1, T_O, 8'h00, 1'b0, 1'b0, 1'b1, "h2_t");
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, (i % 2 == 0) ? R_E : R_O, 8'h00, 1'b0, 1'b0, 1'b0, "h2_ext");
        end
        step(1'b1, 1'b1, C_E, 8'h00, 1'b0, 1'b0, 1'b0, "h2_k2");
        step(1'b1, 1'b1, I_O, 8'h00, 1'b0, 1'b0, 1'b0, "h2_i2");
        step(1'b1, 1'b1, S_E, 8'h55, 1'b1, 1'b0, 1'b1, "h2_sop2");
        step(1'b1, 1'b1, DA5O, 8'hA5, 1'b1, 1'b0, 1'b1, "h2_da5");
        step(1'b1, 1'b1, T_E, 8'h00, 1'b0, 1'b0, 1'b1, "h2_t2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
